// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Stall / flush / clock-enable controller for an NSTAGES-deep in-order
// pipeline (0=IF, 1=ID, 2=EXE, 3=MEM, 4..NSTAGES-2 extra MEM, NSTAGES-1=WB).
// Turns raw hazard and redirect requests into per-stage stall, flush and
// clock-enable vectors, tracks flushed slots (bubbles) as they move down the
// pipe, stretches load-use stalls to LOAD_LAT cycles, and parks IF/ID on a
// self-looping jump until an interrupt redirect arrives.
//
// Optional feature: define PIPE_CTRL_PERF_EN to add saturating stall/flush
// performance counters (parameter CNTW, ports perf_clr, perf_stall_cnt,
// perf_flush_cnt). Without the macro those ports do not exist.
//
// Ports
//   clk, nrst          clock (rising edge), asynchronous active-low reset
//   if_pc, id_pc       PCs in IF and ID, compared for self-loop detection
//   id_is_jump         ID holds an unconditional jump
//   id_is_nop          ID holds a NOP (flushed)
//   isr_pc_flush       interrupt PC redirect
//   isr_pipe_flush     interrupt pipeline flush
//   branch_flush       branch mispredict
//   jump_flush         jump redirect
//   load_hzd_req       raw load-use hazard from the forwarding unit
//   jalr_hzd_req       load->JALR hazard
//   mul_stall          multiplier busy
//   div_running        divider busy
//   wb_wr_en           WB register-file write
//   stall_o            per-stage stall
//   flush_o            per-stage flush (active-high stage reset)
//   clk_en_o           per-stage clock enable
//   bubble_o           registered "stage holds a flushed slot"
//   load_stall_o       load-use stall active
//   loop_idle_o        parked on a self-loop
//   rf_clk_en          register-file clock enable
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int NSTAGES  = 5,
    parameter int PCW      = 12,
    parameter int LOAD_LAT = 1
`ifdef PIPE_CTRL_PERF_EN
    ,
    parameter int CNTW     = 16
`endif
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic [PCW-1:0]     if_pc,
    input  logic [PCW-1:0]     id_pc,
    input  logic               id_is_jump,
    input  logic               id_is_nop,
    input  logic               isr_pc_flush,
    input  logic               isr_pipe_flush,
    input  logic               branch_flush,
    input  logic               jump_flush,
    input  logic               load_hzd_req,
    input  logic               jalr_hzd_req,
    input  logic               mul_stall,
    input  logic               div_running,
    input  logic               wb_wr_en,
    output logic [NSTAGES-1:0] stall_o,
    output logic [NSTAGES-1:0] flush_o,
    output logic [NSTAGES-1:0] clk_en_o,
    output logic [NSTAGES-1:0] bubble_o,
    output logic               load_stall_o,
    output logic               loop_idle_o,
    output logic               rf_clk_en
`ifdef PIPE_CTRL_PERF_EN
    ,
    input  logic               perf_clr,
    output logic [CNTW-1:0]    perf_stall_cnt,
    output logic [CNTW-1:0]    perf_flush_cnt
`endif
);

    // Counter wide enough to hold LOAD_LAT-1; kept at one bit when LOAD_LAT=1.
    localparam int LCW = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LSTALL = 1'b1;

    logic [0:0]     state;
    logic [LCW-1:0] lcnt;
    logic           load_trig;
    logic           fs;
    logic           lj;

    // A load hazard behind a bubble in MEM is not real: the producing slot
    // was flushed, so no stall is started.
    assign load_trig = (state == ST_IDLE) & load_hzd_req & ~bubble_o[3] & ~isr_pipe_flush;

    always_comb begin
        load_stall_o = 1'b0;
        if (isr_pipe_flush) begin
            load_stall_o = 1'b0;
        end else if (state == ST_IDLE) begin
            load_stall_o = load_trig;
        end else begin
            load_stall_o = (lcnt != '0);
        end
    end

    // Load FSM: the trigger cycle is the first stall cycle, LSTALL supplies
    // the remaining LOAD_LAT-1 cycles and then one idle cycle while exiting.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= ST_IDLE;
            lcnt  <= '0;
        end else if (isr_pipe_flush) begin
            state <= ST_IDLE;
            lcnt  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (load_trig && (LOAD_LAT > 1)) begin
                        state <= ST_LSTALL;
                        lcnt  <= LCW'(LOAD_LAT - 1);
                    end
                end
                default: begin
                    if (lcnt == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        lcnt <= lcnt - 1'b1;
                    end
                end
            endcase
        end
    end

    assign fs = load_stall_o | jalr_hzd_req | div_running | mul_stall;

    // Self-looping jump: only counts when the front end is not stalled,
    // otherwise the jump has not really executed yet.
    assign lj = (if_pc == id_pc) & id_is_jump & ~fs;

    always_comb begin
        stall_o    = '0;
        stall_o[0] = fs;
        stall_o[1] = fs;
        stall_o[2] = load_stall_o | div_running | mul_stall;
    end

    always_comb begin
        flush_o    = '0;
        flush_o[0] = isr_pc_flush;
        flush_o[1] = isr_pipe_flush | jump_flush | branch_flush | id_is_nop;
        flush_o[2] = jalr_hzd_req | branch_flush;
        // MEM receives a bubble while EXE is held.
        flush_o[3] = load_stall_o | div_running | mul_stall;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            bubble_o <= '0;
        end else begin
            bubble_o[0] <= flush_o[0];
            for (int i = 1; i < NSTAGES; i++) begin
                bubble_o[i] <= bubble_o[i-1] | flush_o[i];
            end
        end
    end

    // Interrupt redirects release the park and win over a new loop detect.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            loop_idle_o <= 1'b0;
        end else if (isr_pc_flush || isr_pipe_flush) begin
            loop_idle_o <= 1'b0;
        end else if (lj) begin
            loop_idle_o <= 1'b1;
        end
    end

    // A stage is not clocked while it stalls or while the slot arriving
    // from the stage before it is a bubble.
    always_comb begin
        clk_en_o    = '1;
        clk_en_o[0] = ~(stall_o[0] | lj | loop_idle_o);
        clk_en_o[1] = ~(stall_o[1] | bubble_o[0] | lj | loop_idle_o);
        clk_en_o[2] = ~(stall_o[2] | bubble_o[1]);
        clk_en_o[3] = ~(flush_o[3] | bubble_o[2]);
        for (int i = 4; i < NSTAGES; i++) begin
            clk_en_o[i] = ~bubble_o[i-1];
        end
    end

    assign rf_clk_en = wb_wr_en;

`ifdef PIPE_CTRL_PERF_EN
    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else if (perf_clr) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (fs) begin
                perf_stall_cnt <= sat_inc(perf_stall_cnt);
            end
            if (|flush_o[1:0]) begin
                perf_flush_cnt <= sat_inc(perf_flush_cnt);
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl (NSTAGES=5, LOAD_LAT=3). Each step drives one
// cycle of inputs just after the rising edge and queues the expected outputs
// for that cycle; the falling-edge checker pops and compares them.
module tb_pipe_hazard_ctrl;

    localparam int F_RST     = 1 << 0;
    localparam int F_JUMP    = 1 << 1;
    localparam int F_NOP     = 1 << 2;
    localparam int F_ISRPC   = 1 << 3;
    localparam int F_ISRPIPE = 1 << 4;
    localparam int F_BR      = 1 << 5;
    localparam int F_JF      = 1 << 6;
    localparam int F_LOAD    = 1 << 7;
    localparam int F_JALR    = 1 << 8;
    localparam int F_MUL     = 1 << 9;
    localparam int F_DIV     = 1 << 10;
    localparam int F_WB      = 1 << 11;
    localparam int F_SAME    = 1 << 12;
    localparam int F_PCLR    = 1 << 13;

    logic        clk;
    logic        nrst;
    logic [11:0] if_pc, id_pc;
    logic        id_is_jump, id_is_nop, isr_pc_flush, isr_pipe_flush;
    logic        branch_flush, jump_flush, load_hzd_req, jalr_hzd_req;
    logic        mul_stall, div_running, wb_wr_en;
    logic [4:0]  stall_o, flush_o, clk_en_o, bubble_o;
    logic        load_stall_o, loop_idle_o, rf_clk_en;
`ifdef PIPE_CTRL_PERF_EN
    logic        perf_clr;
    logic [2:0]  perf_stall_cnt, perf_flush_cnt;
`endif

    typedef struct {
        string      tag;
        logic [4:0] st, fl, ce, bb;
        logic       ls, li, rf;
        int         ps, pf;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   n_vec = 0;
    int   n_err = 0;

    pipe_hazard_ctrl #(
        .NSTAGES (5),
        .PCW     (12),
        .LOAD_LAT(3)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .CNTW    (3)
`endif
    ) dut (
        .clk           (clk),
        .nrst          (nrst),
        .if_pc         (if_pc),
        .id_pc         (id_pc),
        .id_is_jump    (id_is_jump),
        .id_is_nop     (id_is_nop),
        .isr_pc_flush  (isr_pc_flush),
        .isr_pipe_flush(isr_pipe_flush),
        .branch_flush  (branch_flush),
        .jump_flush    (jump_flush),
        .load_hzd_req  (load_hzd_req),
        .jalr_hzd_req  (jalr_hzd_req),
        .mul_stall     (mul_stall),
        .div_running   (div_running),
        .wb_wr_en      (wb_wr_en),
        .stall_o       (stall_o),
        .flush_o       (flush_o),
        .clk_en_o      (clk_en_o),
        .bubble_o      (bubble_o),
        .load_stall_o  (load_stall_o),
        .loop_idle_o   (loop_idle_o),
        .rf_clk_en     (rf_clk_en)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .perf_clr      (perf_clr),
        .perf_stall_cnt(perf_stall_cnt),
        .perf_flush_cnt(perf_flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input string tag, input int f,
                        input logic [4:0] st, input logic [4:0] fl,
                        input logic [4:0] ce, input logic [4:0] bb,
                        input logic ls, input logic li,
                        input int ps = -1, input int pf = -1);
        exp_t e;
        @(posedge clk);
        #1;
        nrst           = ((f & F_RST) == 0);
        if_pc          = ((f & F_SAME) != 0) ? 12'h040 : 12'h010;
        id_pc          = 12'h040;
        id_is_jump     = ((f & F_JUMP) != 0);
        id_is_nop      = ((f & F_NOP) != 0);
        isr_pc_flush   = ((f & F_ISRPC) != 0);
        isr_pipe_flush = ((f & F_ISRPIPE) != 0);
        branch_flush   = ((f & F_BR) != 0);
        jump_flush     = ((f & F_JF) != 0);
        load_hzd_req   = ((f & F_LOAD) != 0);
        jalr_hzd_req   = ((f & F_JALR) != 0);
        mul_stall      = ((f & F_MUL) != 0);
        div_running    = ((f & F_DIV) != 0);
        wb_wr_en       = ((f & F_WB) != 0);
`ifdef PIPE_CTRL_PERF_EN
        perf_clr       = ((f & F_PCLR) != 0);
`endif
        e.tag = tag; e.st = st; e.fl = fl; e.ce = ce; e.bb = bb;
        e.ls = ls; e.li = li; e.rf = ((f & F_WB) != 0);
        e.ps = ps; e.pf = pf;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            cur = sb.pop_front();
            check({cur.tag, ".stall"},  32'(stall_o),      32'(cur.st));
            check({cur.tag, ".flush"},  32'(flush_o),      32'(cur.fl));
            check({cur.tag, ".clk_en"}, 32'(clk_en_o),     32'(cur.ce));
            check({cur.tag, ".bubble"}, 32'(bubble_o),     32'(cur.bb));
            check({cur.tag, ".ldstl"},  32'(load_stall_o), 32'(cur.ls));
            check({cur.tag, ".loop"},   32'(loop_idle_o),  32'(cur.li));
            check({cur.tag, ".rf_en"},  32'(rf_clk_en),    32'(cur.rf));
`ifdef PIPE_CTRL_PERF_EN
            if (cur.ps >= 0) check({cur.tag, ".pstall"}, 32'(perf_stall_cnt), cur.ps);
            if (cur.pf >= 0) check({cur.tag, ".pflush"}, 32'(perf_flush_cnt), cur.pf);
`endif
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        nrst = 1'b0; if_pc = 12'h010; id_pc = 12'h040;
        id_is_jump = 0; id_is_nop = 0; isr_pc_flush = 0; isr_pipe_flush = 0;
        branch_flush = 0; jump_flush = 0; load_hzd_req = 0; jalr_hzd_req = 0;
        mul_stall = 0; div_running = 0; wb_wr_en = 0;
`ifdef PIPE_CTRL_PERF_EN
        perf_clr = 0;
`endif
        // reset and idle
        step("rst0", F_RST,  5'b00000, 5'b00000, 5'b11111, 5'b00000, 0, 0);
        step("idle", 0,      5'b00000, 5'b00000, 5'b11111, 5'b00000, 0, 0);
        // three-cycle load-use stall from a one-cycle request
        step("ld1",  F_LOAD, 5'b00111, 5'b01000, 5'b10000, 5'b00000, 1, 0);
        step("ld2",  0,      5'b00111, 5'b01000, 5'b00000, 5'b01000, 1, 0);
        step("ld3",  0,      5'b00111, 5'b01000, 5'b00000, 5'b11000, 1, 0);
        step("ld4",  0,      5'b00000, 5'b00000, 5'b01111, 5'b11000, 0, 0);
        step("ld5",  0,      5'b00000, 5'b00000, 5'b11111, 5'b10000, 0, 0);
        step("ld6",  0,      5'b00000, 5'b00000, 5'b11111, 5'b00000, 0, 0);
        // branch flush and bubble propagation
        step("br1",  F_BR,   5'b00000, 5'b00110, 5'b11111, 5'b00000, 0, 0);
        step("br2",  0,      5'b00000, 5'b00000, 5'b10011, 5'b00110, 0, 0);
        step("br3",  0,      5'b00000, 5'b00000, 5'b00111, 5'b01100, 0, 0);
        step("br4",  0,      5'b00000, 5'b00000, 5'b01111, 5'b11000, 0, 0);
        step("br5",  0,      5'b00000, 5'b00000, 5'b11111, 5'b10000, 0, 0);
        step("br6",  0,      5'b00000, 5'b00000, 5'b11111, 5'b00000, 0, 0);
        // jump with differing PCs is not a self-loop
        step("jdif", F_JUMP, 5'b00000, 5'b00000, 5'b11111, 5'b00000, 0, 0);
        // self-loop park, released by isr_pc_flush
        step("lp1",  F_JUMP | F_SAME, 5'b00000, 5'b00000, 5'b11100, 5'b00000, 0, 0);
        step("lp2",  0,               5'b00000, 5'b00000, 5'b11100, 5'b00000, 0, 1);
        step("lp3",  F_WB,            5'b00000, 5'b00000, 5'b11100, 5'b00000, 0, 1);
        step("lp4",  F_ISRPC,         5'b00000, 5'b00001, 5'b11100, 5'b00000, 0, 1);
        step("lp5",  0,               5'b00000, 5'b00000, 5'b11101, 5'b00001, 0, 0);
        step("lp6",  0,               5'b00000, 5'b00000, 5'b11011, 5'b00010, 0, 0);
        step("lp7",  0,               5'b00000, 5'b00000, 5'b10111, 5'b00100, 0, 0);
        step("lp8",  0,               5'b00000, 5'b00000, 5'b01111, 5'b01000, 0, 0);
        step("lp9",  0,               5'b00000, 5'b00000, 5'b11111, 5'b10000, 0, 0);
        // clear beats set when loop detect and isr_pipe_flush coincide
        step("lc1",  F_JUMP | F_SAME | F_ISRPIPE, 5'b00000, 5'b00010, 5'b11100, 5'b00000, 0, 0);
        step("lc2",  0,               5'b00000, 5'b00000, 5'b11011, 5'b00010, 0, 0);
        step("lc3",  0,               5'b00000, 5'b00000, 5'b10111, 5'b00100, 0, 0);
        step("lc4",  0,               5'b00000, 5'b00000, 5'b01111, 5'b01000, 0, 0);
        step("lc5",  0,               5'b00000, 5'b00000, 5'b11111, 5'b10000, 0, 0);
        // stalled front end suppresses loop detect; load behind MEM bubble ignored
        step("ls1",  F_JUMP | F_SAME | F_MUL, 5'b00111, 5'b01000, 5'b10000, 5'b00000, 0, 0);
        step("ls2",  F_LOAD,          5'b00000, 5'b00000, 5'b01111, 5'b01000, 0, 0);
        step("ls3",  0,               5'b00000, 5'b00000, 5'b11111, 5'b10000, 0, 0);
        step("ls4",  0,               5'b00000, 5'b00000, 5'b11111, 5'b00000, 0, 0);
        // isr_pipe_flush in the first LSTALL cycle
        step("if1",  F_LOAD,          5'b00111, 5'b01000, 5'b10000, 5'b00000, 1, 0);
        step("if2",  F_ISRPIPE,       5'b00000, 5'b00010, 5'b01111, 5'b01000, 0, 0);
        step("if3",  0,               5'b00000, 5'b00000, 5'b11011, 5'b10010, 0, 0);
        step("if4",  0,               5'b00000, 5'b00000, 5'b10111, 5'b00100, 0, 0);
        step("if5",  0,               5'b00000, 5'b00000, 5'b01111, 5'b01000, 0, 0);
        step("if6",  0,               5'b00000, 5'b00000, 5'b11111, 5'b10000, 0, 0);
        step("if7",  0,               5'b00000, 5'b00000, 5'b11111, 5'b00000, 0, 0);
        // asynchronous reset in the middle of a load stall
        step("rl1",  F_LOAD,          5'b00111, 5'b01000, 5'b10000, 5'b00000, 1, 0);
        step("rl2",  0,               5'b00111, 5'b01000, 5'b00000, 5'b01000, 1, 0);
        step("rl3",  F_RST,           5'b00000, 5'b00000, 5'b11111, 5'b00000, 0, 0);
        step("rl4",  0,               5'b00000, 5'b00000, 5'b11111, 5'b00000, 0, 0);
        // mixed hazards: flushes do not suppress stalls
        step("mx1",  F_JALR | F_NOP | F_WB, 5'b00011, 5'b00110, 5'b11100, 5'b00000, 0, 0);
        step("mx2",  F_DIV | F_JF,    5'b00111, 5'b01010, 5'b10000, 5'b00110, 0, 0);
        step("mx3",  0,               5'b00000, 5'b00000, 5'b00011, 5'b01110, 0, 0);
        step("mx4",  0,               5'b00000, 5'b00000, 5'b00111, 5'b11100, 0, 0);
        step("mx5",  0,               5'b00000, 5'b00000, 5'b01111, 5'b11000, 0, 0);
        step("mx6",  0,               5'b00000, 5'b00000, 5'b11111, 5'b10000, 0, 0);
        step("mx7",  0,               5'b00000, 5'b00000, 5'b11111, 5'b00000, 0, 0);
`ifdef PIPE_CTRL_PERF_EN
        // divider busy five cycles, then clear
        step("pc0",  F_PCLR,          5'b00000, 5'b00000, 5'b11111, 5'b00000, 0, 0);
        step("pd1",  F_DIV,           5'b00111, 5'b01000, 5'b10000, 5'b00000, 0, 0, 0, 0);
        step("pd2",  F_DIV,           5'b00111, 5'b01000, 5'b00000, 5'b01000, 0, 0, 1, 0);
        step("pd3",  F_DIV,           5'b00111, 5'b01000, 5'b00000, 5'b11000, 0, 0, 2, 0);
        step("pd4",  F_DIV,           5'b00111, 5'b01000, 5'b00000, 5'b11000, 0, 0, 3, 0);
        step("pd5",  F_DIV,           5'b00111, 5'b01000, 5'b00000, 5'b11000, 0, 0, 4, 0);
        step("pd6",  0,               5'b00000, 5'b00000, 5'b01111, 5'b11000, 0, 0, 5, 0);
        step("pd7",  F_PCLR | F_ISRPC, 5'b00000, 5'b00001, 5'b11111, 5'b10000, 0, 0, 5, 0);
        step("pd8",  0,               5'b00000, 5'b00000, 5'b11101, 5'b00001, 0, 0, 0, 0);
        step("pd9",  F_ISRPC,         5'b00000, 5'b00001, 5'b11011, 5'b00010, 0, 0, 0, 0);
        step("pd10", 0,               5'b00000, 5'b00000, 5'b10101, 5'b00101, 0, 0, 0, 1);
        step("pd11", 0,               5'b00000, 5'b00000, 5'b01011, 5'b01010, 0, 0);
        step("pd12", 0,               5'b00000, 5'b00000, 5'b10111, 5'b10100, 0, 0);
        step("pd13", 0,               5'b00000, 5'b00000, 5'b01111, 5'b01000, 0, 0);
        step("pd14", 0,               5'b00000, 5'b00000, 5'b11111, 5'b10000, 0, 0);
        // saturation of the 3-bit stall counter
        step("ps0",  F_PCLR,          5'b00000, 5'b00000, 5'b11111, 5'b00000, 0, 0);
        for (int i = 0; i < 9; i++) begin
            step("psat", F_DIV, 5'b00111, 5'b01000,
                 (i == 0) ? 5'b10000 : 5'b00000,
                 (i == 0) ? 5'b00000 : ((i == 1) ? 5'b01000 : 5'b11000),
                 0, 0, (i > 7) ? 7 : i, 0);
        end
        step("ps1",  0,               5'b00000, 5'b00000, 5'b01111, 5'b11000, 0, 0, 7, 0);
        step("ps2",  0,               5'b00000, 5'b00000, 5'b11111, 5'b10000, 0, 0, 7, 0);
        step("ps3",  0,               5'b00000, 5'b00000, 5'b11111, 5'b00000, 0, 0);
`endif
        @(negedge clk);
        #1;
        check("sb_drain", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
